// File: rtl/memory_datapath_if.sv
// memory_datapath_if
//   Bundles the memory-stage datapath inputs and the registered read port.
//   There is no valid/ready handshake on this bus: every control input is
//   sampled at each rising clock edge and acts in that cycle only.
//
//   Signals:
//     pc, sp_in, reg_in          address candidates (reg_in also write data)
//     MemSrc[1:0]                address select
//     MaryData, ShelleyData      external data for Mary / Shelley
//     RAData                     return-address data
//     MemWrite, MemRead          RAM write / read enables
//     MemDst[2:0]                write-data select
//     MaryWrite, ShelleyWrite,
//     CompWrite, RAWrite         register load enables
//     MarySrc[1:0], ShelleySrc   Mary / Shelley input selects
//     mem_out                    registered RAM read data (driven by the stage)
//
//   Modports: master drives controls and observes mem_out; slave is the stage.
interface memory_datapath_if;
  logic [15:0] pc;
  logic [15:0] sp_in;
  logic [15:0] reg_in;
  logic [1:0]  MemSrc;
  logic [15:0] MaryData;
  logic [15:0] ShelleyData;
  logic [15:0] RAData;
  logic        MemWrite;
  logic        MemRead;
  logic [2:0]  MemDst;
  logic        MaryWrite;
  logic        ShelleyWrite;
  logic        CompWrite;
  logic        RAWrite;
  logic [1:0]  MarySrc;
  logic [1:0]  ShelleySrc;
  logic [15:0] mem_out;

  modport master (
    output pc, sp_in, reg_in, MemSrc, MaryData, ShelleyData, RAData,
    output MemWrite, MemRead, MemDst, MaryWrite, ShelleyWrite, CompWrite,
    output RAWrite, MarySrc, ShelleySrc,
    input  mem_out
  );

  modport slave (
    input  pc, sp_in, reg_in, MemSrc, MaryData, ShelleyData, RAData,
    input  MemWrite, MemRead, MemDst, MaryWrite, ShelleyWrite, CompWrite,
    input  RAWrite, MarySrc, ShelleySrc,
    output mem_out
  );
endinterface

// File: rtl/memory_datapath.sv
// memory_datapath
//   Memory stage of the 16-bit 3V datapath: a word-addressed RAM with an
//   address-select mux and a write-data-select mux, plus the architectural
//   registers Mary, Shelley, Comp and RA.
//
//   Ports:
//     clock    rising-edge system clock
//     reset_n  asynchronous active-low reset (clears mem_out and registers,
//              blocks RAM writes; RAM contents are kept)
//     bus      memory_datapath_if.slave (controls in, mem_out out)
//
//   Parameters:
//     ADDR_WIDTH  RAM address bits; depth is 2**ADDR_WIDTH words
//     DATA_WIDTH  word width, fixed at 16
module memory_datapath #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input logic              clock,
  input logic              reset_n,
  memory_datapath_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DATA_WIDTH-1:0] memOutReg;
  logic [DATA_WIDTH-1:0] maryReg;
  logic [DATA_WIDTH-1:0] shelleyReg;
  logic [DATA_WIDTH-1:0] compReg;
  logic [DATA_WIDTH-1:0] raReg;

  logic [15:0]           addrSel;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [15:0]           unusedAddrHi;
  logic [DATA_WIDTH-1:0] writeData;
  logic [DATA_WIDTH-1:0] maryNext;
  logic [DATA_WIDTH-1:0] shelleyNext;

  // Address select
  always_comb begin
    addrSel = bus.pc;
    case (bus.MemSrc)
      2'b00:   addrSel = bus.pc;
      2'b01:   addrSel = bus.sp_in;
      2'b10:   addrSel = bus.reg_in;
      default: addrSel = compReg;
    endcase
  end

  // Addresses wrap modulo the RAM depth; the upper bits are dropped.
  assign memAddr      = addrSel[ADDR_WIDTH-1:0];
  assign unusedAddrHi = addrSel >> ADDR_WIDTH;

  // Write-data select
  always_comb begin
    writeData = maryReg;
    case (bus.MemDst)
      3'b000:  writeData = maryReg;
      3'b001:  writeData = bus.MaryData;
      3'b010:  writeData = shelleyReg;
      3'b011:  writeData = bus.ShelleyData;
      3'b100:  writeData = raReg;
      3'b101:  writeData = bus.RAData;
      3'b110:  writeData = compReg;
      default: writeData = bus.reg_in;
    endcase
  end

  // Register input selects; both read pre-edge values so Mary<-Shelley and
  // Shelley<-Mary in one cycle swap the two.
  always_comb begin
    maryNext = bus.MaryData;
    case (bus.MarySrc)
      2'b00:   maryNext = bus.MaryData;
      2'b01:   maryNext = memOutReg;
      2'b10:   maryNext = shelleyReg;
      default: maryNext = compReg;
    endcase
  end

  always_comb begin
    shelleyNext = bus.ShelleyData;
    case (bus.ShelleySrc)
      2'b00:   shelleyNext = bus.ShelleyData;
      2'b01:   shelleyNext = memOutReg;
      2'b10:   shelleyNext = maryReg;
      default: shelleyNext = compReg;
    endcase
  end

  // RAM array: never cleared, only write-blocked while reset is asserted,
  // so a write either lands whole at an edge or not at all.
  always_ff @(posedge clock or negedge reset_n) begin
    if (reset_n) begin
      if (bus.MemWrite) begin
        mem[memAddr] <= writeData;
      end
    end
  end

  // Read port and architectural registers. The read samples the array
  // before any same-edge write lands, giving read-first behaviour.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      memOutReg  <= '0;
      maryReg    <= '0;
      shelleyReg <= '0;
      compReg    <= '0;
      raReg      <= '0;
    end else begin
      if (bus.MemRead) begin
        memOutReg <= mem[memAddr];
      end
      if (bus.MaryWrite) begin
        maryReg <= maryNext;
      end
      if (bus.ShelleyWrite) begin
        shelleyReg <= shelleyNext;
      end
      if (bus.CompWrite) begin
        compReg <= memOutReg;
      end
      if (bus.RAWrite) begin
        raReg <= bus.RAData;
      end
    end
  end

  assign bus.mem_out = memOutReg;

endmodule

// File: tb/tb_memory_datapath.sv
module tb_memory_datapath;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

  memory_datapath_if bus();

  memory_datapath #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // driver tasks
  task automatic idle();
    bus.pc           = '0;
    bus.sp_in        = '0;
    bus.reg_in       = '0;
    bus.MemSrc       = 2'b00;
    bus.MaryData     = '0;
    bus.ShelleyData  = '0;
    bus.RAData       = '0;
    bus.MemWrite     = 1'b0;
    bus.MemRead      = 1'b0;
    bus.MemDst       = 3'b000;
    bus.MaryWrite    = 1'b0;
    bus.ShelleyWrite = 1'b0;
    bus.CompWrite    = 1'b0;
    bus.RAWrite      = 1'b0;
    bus.MarySrc      = 2'b00;
    bus.ShelleySrc   = 2'b00;
  endtask

  // one rising edge, then settle 1 time unit past it
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // write word selected by MemDst to address reg_in (MemSrc=10)
  task automatic write_reg_addr(input logic [15:0] addr, input logic [2:0] dst,
                                input logic [15:0] rin);
    idle();
    bus.MemSrc   = 2'b10;
    bus.reg_in   = (dst == 3'b111) ? rin : addr;
    bus.MemDst   = dst;
    bus.MemWrite = 1'b1;
    tick();
    idle();
  endtask

  // write via sp_in address so reg_in can carry the data
  task automatic write_sp(input logic [15:0] addr, input logic [15:0] data);
    idle();
    bus.MemSrc   = 2'b01;
    bus.sp_in    = addr;
    bus.reg_in   = data;
    bus.MemDst   = 3'b111;
    bus.MemWrite = 1'b1;
    tick();
    idle();
  endtask

  task automatic read_sp(input logic [15:0] addr);
    idle();
    bus.MemSrc  = 2'b01;
    bus.sp_in   = addr;
    bus.MemRead = 1'b1;
    tick();
    idle();
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b1;
    idle();
    #1 reset_n = 1'b0;
    tick();
    tick();
    check("reset_mem_out", bus.mem_out, 16'h0000);
    #2 reset_n = 1'b1;

    // write MaryData=127 to pc=0, then read it back
    idle();
    bus.MemWrite = 1'b1;
    bus.MemDst   = 3'b001;
    bus.MemSrc   = 2'b00;
    bus.pc       = 16'h0000;
    bus.MaryData = 16'd127;
    tick();
    idle();
    bus.MemRead = 1'b1;
    tick();
    check("pc_write_read", bus.mem_out, 16'd127);

    // reg_in data to sp_in=5, read back by reg_in address, including wrap
    write_sp(16'd5, 16'hBEEF);
    bus.MemSrc  = 2'b10;
    bus.reg_in  = 16'd5;
    bus.MemRead = 1'b1;
    tick();
    check("reg_addr_read", bus.mem_out, 16'hBEEF);
    bus.reg_in = 16'd0;
    tick();
    check("read_addr0", bus.mem_out, 16'd127);
    bus.reg_in = 16'h0405;
    tick();
    check("addr_wrap", bus.mem_out, 16'hBEEF);
    bus.reg_in  = 16'd0;
    bus.MemRead = 1'b0;
    tick();
    check("read_hold", bus.mem_out, 16'hBEEF);

    // load Mary/Shelley from external data, then swap
    idle();
    bus.MaryWrite    = 1'b1;
    bus.MaryData     = 16'h1234;
    bus.ShelleyWrite = 1'b1;
    bus.ShelleyData  = 16'h5678;
    tick();
    bus.MarySrc    = 2'b10;
    bus.ShelleySrc = 2'b10;
    bus.MaryData    = 16'h0000;
    bus.ShelleyData = 16'h0000;
    tick();
    idle();
    write_reg_addr(16'd20, 3'b000, 16'h0);
    write_reg_addr(16'd21, 3'b010, 16'h0);
    read_sp(16'd20);
    check("swap_mary", bus.mem_out, 16'h5678);
    read_sp(16'd21);
    check("swap_shelley", bus.mem_out, 16'h1234);

    // Comp as an indirect address
    write_sp(16'd3, 16'h0009);
    write_sp(16'd9, 16'h00AA);
    read_sp(16'd3);
    check("read_addr3", bus.mem_out, 16'h0009);
    bus.CompWrite = 1'b1;
    tick();
    idle();
    bus.MemSrc  = 2'b11;
    bus.MemRead = 1'b1;
    tick();
    check("comp_indirect", bus.mem_out, 16'h00AA);
    write_reg_addr(16'd30, 3'b110, 16'h0);
    read_sp(16'd30);
    check("comp_writeout", bus.mem_out, 16'h0009);

    // same-address read+write is read-first
    write_sp(16'd7, 16'h0001);
    bus.MemSrc   = 2'b01;
    bus.sp_in    = 16'd7;
    bus.reg_in   = 16'h0002;
    bus.MemDst   = 3'b111;
    bus.MemWrite = 1'b1;
    bus.MemRead  = 1'b1;
    tick();
    check("rw_old_data", bus.mem_out, 16'h0001);
    bus.MemWrite = 1'b0;
    tick();
    check("rw_new_data", bus.mem_out, 16'h0002);

    // RA register and RAData paths
    idle();
    bus.RAWrite = 1'b1;
    bus.RAData  = 16'hCAFE;
    tick();
    idle();
    write_reg_addr(16'd40, 3'b100, 16'h0);
    idle();
    bus.MemSrc   = 2'b10;
    bus.reg_in   = 16'd41;
    bus.MemDst   = 3'b101;
    bus.RAData   = 16'h1111;
    bus.MemWrite = 1'b1;
    tick();
    idle();
    read_sp(16'd40);
    check("ra_reg", bus.mem_out, 16'hCAFE);
    read_sp(16'd41);
    check("ra_data", bus.mem_out, 16'h1111);

    // Mary from mem_out (1111), Shelley from Comp (0009)
    bus.MaryWrite    = 1'b1;
    bus.MarySrc      = 2'b01;
    bus.ShelleyWrite = 1'b1;
    bus.ShelleySrc   = 2'b11;
    tick();
    idle();
    write_reg_addr(16'd42, 3'b000, 16'h0);
    write_reg_addr(16'd43, 3'b010, 16'h0);
    read_sp(16'd42);
    check("mary_from_memout", bus.mem_out, 16'h1111);
    read_sp(16'd43);
    check("shelley_from_comp", bus.mem_out, 16'h0009);

    // async reset between edges, with a write attempted during reset
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_now", bus.mem_out, 16'h0000);
    bus.MemWrite = 1'b1;
    bus.MemDst   = 3'b001;
    bus.MemSrc   = 2'b00;
    bus.pc       = 16'h0000;
    bus.MaryData = 16'hFFFF;
    bus.MemRead  = 1'b1;
    tick();
    check("reset_held", bus.mem_out, 16'h0000);
    idle();
    #2 reset_n = 1'b1;
    write_reg_addr(16'd50, 3'b000, 16'h0);
    write_reg_addr(16'd51, 3'b100, 16'h0);
    read_sp(16'd50);
    check("mary_cleared", bus.mem_out, 16'h0000);
    read_sp(16'd0);
    check("mem_kept", bus.mem_out, 16'd127);
    read_sp(16'd51);
    check("ra_cleared", bus.mem_out, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_datapath.md
Name: memory_datapath

Overview:
- Memory stage of the 16-bit 3V processor datapath.
- Contains a word-addressed data/instruction RAM, an address-select mux and a write-data-select mux.
- Contains four architectural registers: Mary, Shelley, Comp and RA.
- Sits between the register/ALU stage and writeback; the registered read port mem_out feeds the rest of the datapath.

Parameters:
- ADDR_WIDTH, 10, number of RAM address bits (depth = 2^ADDR_WIDTH 16-bit words).
- DATA_WIDTH, 16, word width. Fixed at 16; present for readability only.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pc  in  16  program counter (address candidate).
- sp_in  in  16  stack pointer (address candidate).
- reg_in  in  16  general register value (address candidate / write-data candidate).
- MemSrc  in  2  address select.
- MaryData  in  16  external data for Mary.
- ShelleyData  in  16  external data for Shelley.
- RAData  in  16  return-address data.
- MemWrite  in  1  RAM write enable.
- MemRead  in  1  RAM read enable.
- MemDst  in  3  write-data select.
- MaryWrite  in  1  Mary load enable.
- ShelleyWrite  in  1  Shelley load enable.
- CompWrite  in  1  Comp load enable.
- RAWrite  in  1  RA load enable.
- MarySrc  in  2  Mary input select.
- ShelleySrc  in  2  Shelley input select.
- mem_out  out  16  registered RAM read data.

Behaviour:
- Address mux (combinational), MemSrc:
  - 00 = pc
  - 01 = sp_in
  - 10 = reg_in
  - 11 = Comp register
- Only the low ADDR_WIDTH bits of the selected address are used; upper bits are ignored (addresses wrap modulo depth).
- Write-data mux (combinational), MemDst:
  - 000 = Mary register
  - 001 = MaryData
  - 010 = Shelley register
  - 011 = ShelleyData
  - 100 = RA register
  - 101 = RAData
  - 110 = Comp register
  - 111 = reg_in
- RAM write: at a rising edge with MemWrite=1, mem[addr] <= write data.
- RAM read: at a rising edge with MemRead=1, mem_out <= mem[addr]. With MemRead=0, mem_out holds its value. One-cycle read latency.
- Simultaneous read and write to the same address is read-first: mem_out gets the old contents, and the new data is visible on the next read.
- Mary: at a rising edge with MaryWrite=1, loads per MarySrc:
  - 00 = MaryData
  - 01 = mem_out
  - 10 = Shelley
  - 11 = Comp
- Shelley: at a rising edge with ShelleyWrite=1, loads per ShelleySrc:
  - 00 = ShelleyData
  - 01 = mem_out
  - 10 = Mary
  - 11 = Comp
- Register-to-register loads use pre-edge values, so Mary<-Shelley and Shelley<-Mary in the same cycle performs a swap.
- Comp: at a rising edge with CompWrite=1, Comp <= mem_out.
- RA: at a rising edge with RAWrite=1, RA <= RAData.
- All register loads use the mem_out value present before the edge, not data read in the same cycle.
- Reset (reset_n=0, asynchronous):
  - mem_out, Mary, Shelley, Comp and RA clear to 0 immediately and stay 0 while reset is held.
  - RAM writes are suppressed during reset.
  - RAM contents are not cleared by reset; they are undefined at power-up.
- Reset asserted mid-write: the write either completed at an earlier edge or does not occur; no partial writes.
- No enables are mutually exclusive; all may be active in the same cycle.

Test Plan:
- Reset, then MemWrite=1, MemDst=001, MemSrc=00, pc=0, MaryData=127 for one edge. Then MemRead=1 -> mem_out=127 one edge later.
- Write 16'hBEEF via MemDst=111 to address sp_in=5 (MemSrc=01). Read with MemSrc=10, reg_in=5 -> mem_out=16'hBEEF. Read with reg_in=16'h0405 (ADDR_WIDTH=10) -> 16'hBEEF (wrap).
- Load Mary (MarySrc=00, MaryData=16'h1234) and Shelley (ShelleySrc=00, ShelleyData=16'h5678). Then one edge with MaryWrite=ShelleyWrite=1, MarySrc=10, ShelleySrc=10. Write both out via MemDst=000/010 and read back -> Mary=16'h5678, Shelley=16'h1234.
- mem[3]=16'h0009 and mem[9]=16'h00AA. Read address 3, CompWrite=1. Then MemSrc=11, MemRead=1 -> mem_out=16'h00AA.
- Same-address read+write: mem[7]=16'h0001, then write 16'h0002 with MemRead=1 -> mem_out=16'h0001. Next read -> 16'h0002.
- With nonzero mem_out/Mary, pull reset_n low between edges -> mem_out=0 immediately. After release, write Mary via MemDst=000 and read back -> 0; mem[0] still 127.
